// File: rtl/video_timing_pattern_gen_if.sv
// Parallel video output bus: pixel, syncs, raster position and frame status, all mutually aligned.
interface video_timing_pattern_gen_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 12
);
    logic              vid_de;
    logic              vid_hs;
    logic              vid_vs;
    logic [DATA_W-1:0] vid_r;
    logic [DATA_W-1:0] vid_g;
    logic [DATA_W-1:0] vid_b;
    logic [CNT_W-1:0]  x_pos;
    logic [CNT_W-1:0]  y_pos;
    logic              frame_start;
    logic [15:0]       frame_cnt;
    logic [2:0]        active_pattern;

    modport master (
        output vid_de, vid_hs, vid_vs, vid_r, vid_g, vid_b,
               x_pos, y_pos, frame_start, frame_cnt, active_pattern
    );

    modport slave (
        input  vid_de, vid_hs, vid_vs, vid_r, vid_g, vid_b,
               x_pos, y_pos, frame_start, frame_cnt, active_pattern
    );
endinterface

// File: rtl/video_timing_pattern_gen.sv
// Raster timing and test-pattern generator; every output is registered one enabled cycle after the counter state.
// No backpressure: clk_en is the only stall and freezes all state and outputs in place.
module video_timing_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 12,
    parameter int CHK_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic [2:0]              pattern_sel,
    input  logic [3*DATA_W-1:0]     solid_rgb,
    video_timing_pattern_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
    localparam logic [DATA_W-1:0] FULL    = '1;

    logic [CNT_W-1:0]    h_cnt;
    logic [CNT_W-1:0]    v_cnt;
    logic [CNT_W-1:0]    bar_px;
    logic [2:0]          bar_idx;
    logic [2:0]          pat_q;
    logic [3*DATA_W-1:0] solid_q;
    logic [15:0]         frame_q;

    logic              h_last;
    logic              v_last;
    logic              de_c;
    logic              hs_c;
    logic              vs_c;
    logic [7:0]        scroll;
    logic [DATA_W-1:0] r_c;
    logic [DATA_W-1:0] g_c;
    logic [DATA_W-1:0] b_c;

    always_comb begin
        h_last = (h_cnt == H_LAST);
        v_last = (v_cnt == V_LAST);
        de_c   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_c   = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
        vs_c   = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
        scroll = 8'(h_cnt) - 8'({frame_q, 1'b0});
        r_c    = '0;
        g_c    = '0;
        b_c    = '0;
        if (de_c) begin
            case (pat_q)
                // Bar order white..black maps onto the inverted bits of the bar index.
                3'd0: begin
                    r_c = {DATA_W{~bar_idx[1]}};
                    g_c = {DATA_W{~bar_idx[2]}};
                    b_c = {DATA_W{~bar_idx[0]}};
                end
                3'd1: begin
                    r_c = DATA_W'(h_cnt);
                    g_c = DATA_W'(h_cnt);
                    b_c = DATA_W'(h_cnt);
                end
                3'd2: begin
                    if (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) begin
                        r_c = FULL;
                        g_c = FULL;
                        b_c = FULL;
                    end
                end
                3'd3: {r_c, g_c, b_c} = solid_q;
                3'd4: begin
                    if (scroll < 8'd16) begin
                        r_c = FULL;
                        g_c = FULL;
                        b_c = FULL;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt              <= '0;
            v_cnt              <= '0;
            bar_px             <= '0;
            bar_idx            <= '0;
            pat_q              <= '0;
            solid_q            <= '0;
            frame_q            <= '0;
            vid.vid_de         <= 1'b0;
            vid.vid_hs         <= ~HS_POL;
            vid.vid_vs         <= ~VS_POL;
            vid.vid_r          <= '0;
            vid.vid_g          <= '0;
            vid.vid_b          <= '0;
            vid.x_pos          <= '0;
            vid.y_pos          <= '0;
            vid.frame_start    <= 1'b0;
            vid.frame_cnt      <= '0;
            vid.active_pattern <= '0;
        end else if (clk_en) begin
            h_cnt <= h_last ? '0 : h_cnt + CNT_W'(1);
            if (h_last) begin
                v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
            end

            // Bar position tracked incrementally so no divider sits on the pixel path.
            if (h_last || (bar_px == BAR_LAST)) begin
                bar_px <= '0;
            end else begin
                bar_px <= bar_px + CNT_W'(1);
            end
            if (h_last) begin
                bar_idx <= '0;
            end else if (bar_px == BAR_LAST) begin
                bar_idx <= bar_idx + 3'd1;
            end

            if (h_last && v_last) begin
                pat_q   <= pattern_sel;
                solid_q <= solid_rgb;
                frame_q <= frame_q + 16'd1;
            end

            vid.vid_de         <= de_c;
            vid.vid_hs         <= hs_c;
            vid.vid_vs         <= vs_c;
            vid.vid_r          <= r_c;
            vid.vid_g          <= g_c;
            vid.vid_b          <= b_c;
            vid.x_pos          <= h_cnt;
            vid.y_pos          <= v_cnt;
            vid.frame_start    <= (h_cnt == '0) && (v_cnt == '0);
            vid.frame_cnt      <= frame_q;
            vid.active_pattern <= pat_q;
        end
    end
endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Directed bench for the raster/pattern generator on a 24x8 raster (16x4 active, 2-pixel bars, 2-pixel checks).
module tb_video_timing_pattern_gen;
    localparam int H_ACTIVE = 16;
    localparam int V_ACTIVE = 4;
    localparam int H_TOTAL  = 24;
    localparam int V_TOTAL  = 8;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    typedef struct {
        logic [2:0]  pat;
        logic [23:0] solid;
        int          x;
        int          y;
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [2:0]  pattern_sel;
    logic [23:0] solid_rgb;

    int n_vec = 0;
    int n_err = 0;

    vec_t vt [28];

    video_timing_pattern_gen_if #(.DATA_W(8), .CNT_W(12)) vif ();

    video_timing_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .DATA_W(8), .CNT_W(12), .CHK_LOG2(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .vid         (vif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input int mode, input int x, input int y, input logic [23:0] solid);
        logic [23:0] c;
        c = 24'h0;
        if (x < H_ACTIVE && y < V_ACTIVE) begin
            case (mode)
                0: begin
                    case (x / 2)
                        0: c = 24'hFFFFFF;
                        1: c = 24'hFFFF00;
                        2: c = 24'h00FFFF;
                        3: c = 24'h00FF00;
                        4: c = 24'hFF00FF;
                        5: c = 24'hFF0000;
                        6: c = 24'h0000FF;
                        default: c = 24'h000000;
                    endcase
                end
                1: c = {3{8'(x)}};
                3: c = solid;
                default: c = 24'h0;
            endcase
        end
        return c;
    endfunction

    task automatic wait_new_frame();
        int n = 0;
        while (vif.frame_start === 1'b1 && n < 500) begin @(negedge clk); n++; end
        while (vif.frame_start !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_timeout: no frame_start within 500 cycles");
        end
    endtask

    task automatic wait_pos(input int x, input int y);
        int n = 0;
        while (!(vif.x_pos == 12'(x) && vif.y_pos == 12'(y)) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_vec++;
            n_err++;
            $display("FAIL pos_timeout: (%0d,%0d) not reached in 400 cycles", x, y);
        end
    endtask

    // Walks one whole frame from its frame_start cycle, checking colour and pattern per pixel.
    task automatic check_frame(input int mode, input logic [2:0] pat, input logic [23:0] solid);
        int x, y, de_n;
        de_n = 0;
        for (int k = 0; k < FRAME; k++) begin
            x = k % H_TOTAL;
            y = k / H_TOTAL;
            chk($sformatf("frame_m%0d_k%0d", mode, k),
                {vif.vid_r, vif.vid_g, vif.vid_b, vif.active_pattern},
                {exp_rgb(mode, x, y, solid), pat});
            if (vif.vid_de === 1'b1) de_n++;
            @(negedge clk);
        end
        chk($sformatf("de_per_frame_m%0d", mode), 96'(de_n), 96'd64);
    endtask

    initial begin
        int x, y, cnt;

        vt[0]  = '{3'd0, 24'h0,      0, 0, 1'b1, 1'b0, 1'b0, 24'hFFFFFF};
        vt[1]  = '{3'd0, 24'h0,      1, 0, 1'b1, 1'b0, 1'b0, 24'hFFFFFF};
        vt[2]  = '{3'd0, 24'h0,      2, 0, 1'b1, 1'b0, 1'b0, 24'hFFFF00};
        vt[3]  = '{3'd0, 24'h0,      3, 1, 1'b1, 1'b0, 1'b0, 24'hFFFF00};
        vt[4]  = '{3'd0, 24'h0,      4, 0, 1'b1, 1'b0, 1'b0, 24'h00FFFF};
        vt[5]  = '{3'd0, 24'h0,      6, 2, 1'b1, 1'b0, 1'b0, 24'h00FF00};
        vt[6]  = '{3'd0, 24'h0,      9, 0, 1'b1, 1'b0, 1'b0, 24'hFF00FF};
        vt[7]  = '{3'd0, 24'h0,     10, 3, 1'b1, 1'b0, 1'b0, 24'hFF0000};
        vt[8]  = '{3'd0, 24'h0,     12, 0, 1'b1, 1'b0, 1'b0, 24'h0000FF};
        vt[9]  = '{3'd0, 24'h0,     15, 3, 1'b1, 1'b0, 1'b0, 24'h000000};
        vt[10] = '{3'd0, 24'h0,     16, 0, 1'b0, 1'b0, 1'b0, 24'h000000};
        vt[11] = '{3'd0, 24'h0,     19, 1, 1'b0, 1'b1, 1'b0, 24'h000000};
        vt[12] = '{3'd0, 24'h0,     23, 2, 1'b0, 1'b0, 1'b0, 24'h000000};
        vt[13] = '{3'd0, 24'h0,      3, 5, 1'b0, 1'b0, 1'b1, 24'h000000};
        vt[14] = '{3'd0, 24'h0,     20, 6, 1'b0, 1'b1, 1'b1, 24'h000000};
        vt[15] = '{3'd0, 24'h0,      0, 7, 1'b0, 1'b0, 1'b0, 24'h000000};
        vt[16] = '{3'd2, 24'h0,      0, 0, 1'b1, 1'b0, 1'b0, 24'h000000};
        vt[17] = '{3'd2, 24'h0,      2, 0, 1'b1, 1'b0, 1'b0, 24'hFFFFFF};
        vt[18] = '{3'd2, 24'h0,      2, 2, 1'b1, 1'b0, 1'b0, 24'h000000};
        vt[19] = '{3'd2, 24'h0,      1, 3, 1'b1, 1'b0, 1'b0, 24'hFFFFFF};
        vt[20] = '{3'd1, 24'h0,      5, 1, 1'b1, 1'b0, 1'b0, 24'h050505};
        vt[21] = '{3'd1, 24'h0,     15, 3, 1'b1, 1'b0, 1'b0, 24'h0F0F0F};
        vt[22] = '{3'd1, 24'h0,     17, 1, 1'b0, 1'b0, 1'b0, 24'h000000};
        vt[23] = '{3'd3, 24'hA1B2C3, 7, 2, 1'b1, 1'b0, 1'b0, 24'hA1B2C3};
        vt[24] = '{3'd3, 24'hA1B2C3, 20, 2, 1'b0, 1'b1, 1'b0, 24'h000000};
        vt[25] = '{3'd5, 24'hA1B2C3, 0, 0, 1'b1, 1'b0, 1'b0, 24'h000000};
        vt[26] = '{3'd7, 24'h0,      8, 1, 1'b1, 1'b0, 1'b0, 24'h000000};
        vt[27] = '{3'd6, 24'h0,      3, 0, 1'b1, 1'b0, 1'b0, 24'h000000};

        reset       = 1'b1;
        clk_en      = 1'b1;
        pattern_sel = 3'd0;
        solid_rgb   = 24'h0;
        repeat (3) @(negedge clk);
        chk("reset_state",
            {vif.x_pos, vif.y_pos, vif.vid_de, vif.vid_hs, vif.vid_vs, vif.frame_start,
             vif.frame_cnt, vif.vid_r, vif.vid_g, vif.vid_b, vif.active_pattern}, 96'd0);

        // Two free-running frames: position, syncs, frame pulse/count and colour bars.
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k <= 2 * FRAME; k++) begin
            x = k % H_TOTAL;
            y = (k / H_TOTAL) % V_TOTAL;
            chk($sformatf("timing_k%0d", k),
                {vif.x_pos, vif.y_pos, vif.vid_de, vif.vid_hs, vif.vid_vs, vif.frame_start,
                 vif.frame_cnt, vif.vid_r, vif.vid_g, vif.vid_b},
                {12'(x), 12'(y), (x < H_ACTIVE && y < V_ACTIVE), (x >= 18 && x <= 20),
                 (y >= 5 && y <= 6), (k % FRAME == 0), 16'(k / FRAME), exp_rgb(0, x, y, 24'h0)});
            if (k < 2 * FRAME) @(negedge clk);
        end

        // Mid-frame request must wait for the next frame boundary.
        repeat (30) @(negedge clk);
        pattern_sel = 3'd3;
        solid_rgb   = 24'h123456;
        wait_pos(2, 2);
        chk("midframe_still_bars", {vif.vid_r, vif.vid_g, vif.vid_b, vif.active_pattern},
            {24'hFFFF00, 3'd0});
        wait_new_frame();
        check_frame(3, 3'd3, 24'h123456);

        // Stall 10 cycles at (7,1): outputs frozen, period stretches to 202.
        wait_new_frame();
        cnt = 0;
        while (!(vif.x_pos == 12'd7 && vif.y_pos == 12'd1) && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        clk_en = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            cnt++;
            chk($sformatf("hold_%0d", i),
                {vif.x_pos, vif.y_pos, vif.vid_de, vif.vid_hs, vif.vid_vs, vif.frame_start,
                 vif.vid_r, vif.vid_g, vif.vid_b, vif.active_pattern},
                {12'd7, 12'd1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h123456, 3'd3});
        end
        clk_en = 1'b1;
        @(negedge clk);
        cnt++;
        chk("resume_pos", {vif.x_pos, vif.y_pos}, {12'd8, 12'd1});
        while (vif.frame_start !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        chk("stretched_period", 96'(cnt), 96'd202);

        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("fs_hold_%0d", i), {vif.frame_start, vif.x_pos, vif.y_pos},
                {1'b1, 12'd0, 12'd0});
        end
        clk_en = 1'b1;
        @(negedge clk);
        chk("fs_drop", {vif.frame_start, vif.x_pos}, {1'b0, 12'd1});

        // Asynchronous reset in the middle of a line with the solid pattern active.
        wait_pos(5, 2);
        reset       = 1'b1;
        pattern_sel = 3'd4;
        solid_rgb   = 24'h0;
        #1;
        chk("reset_async",
            {vif.x_pos, vif.y_pos, vif.vid_de, vif.vid_hs, vif.vid_vs, vif.frame_start,
             vif.frame_cnt, vif.vid_r, vif.vid_g, vif.vid_b, vif.active_pattern}, 96'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_origin",
            {vif.frame_start, vif.x_pos, vif.y_pos, vif.vid_de, vif.vid_r, vif.vid_g, vif.vid_b,
             vif.frame_cnt, vif.active_pattern},
            {1'b1, 12'd0, 12'd0, 1'b1, 24'hFFFFFF, 16'd0, 3'd0});
        @(negedge clk);
        @(negedge clk);
        chk("post_reset_bars", {vif.x_pos, vif.vid_r, vif.vid_g, vif.vid_b, vif.active_pattern},
            {12'd2, 24'hFFFF00, 3'd0});

        // Scrolling bar: frame 1 offset 2, frame 2 offset 4.
        wait_new_frame();
        chk("scroll_f1_x0", {vif.frame_cnt, vif.active_pattern, vif.vid_r, vif.vid_g, vif.vid_b},
            {16'd1, 3'd4, 24'h000000});
        @(negedge clk);
        chk("scroll_f1_x1", {vif.x_pos, vif.vid_r, vif.vid_g, vif.vid_b}, {12'd1, 24'h000000});
        @(negedge clk);
        chk("scroll_f1_x2", {vif.x_pos, vif.vid_r, vif.vid_g, vif.vid_b}, {12'd2, 24'hFFFFFF});
        wait_pos(15, 3);
        chk("scroll_f1_x15", {vif.vid_r, vif.vid_g, vif.vid_b}, 96'hFFFFFF);
        wait_new_frame();
        wait_pos(3, 0);
        chk("scroll_f2_x3", {vif.frame_cnt, vif.vid_r, vif.vid_g, vif.vid_b}, {16'd2, 24'h000000});
        @(negedge clk);
        chk("scroll_f2_x4", {vif.x_pos, vif.vid_r, vif.vid_g, vif.vid_b}, {12'd4, 24'hFFFFFF});

        // Grey ramp across a whole frame.
        pattern_sel = 3'd1;
        wait_new_frame();
        check_frame(1, 3'd1, 24'h0);

        for (int i = 0; i < 28; i++) begin
            if (i == 0 || vt[i].pat != vt[i-1].pat || vt[i].solid != vt[i-1].solid) begin
                pattern_sel = vt[i].pat;
                solid_rgb   = vt[i].solid;
                wait_new_frame();
            end
            wait_pos(vt[i].x, vt[i].y);
            chk($sformatf("vec%0d", i),
                {vif.vid_de, vif.vid_hs, vif.vid_vs, vif.vid_r, vif.vid_g, vif.vid_b, vif.active_pattern},
                {vt[i].de, vt[i].hs, vt[i].vs, vt[i].rgb, vt[i].pat});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/video_timing_pattern_gen.md
Name: video_timing_pattern_gen

Overview:
Parametrised raster timing and test-pattern generator that drives the ADV7513 parallel video bus (pclk domain) for the HDMI TX path. It replaces fixed per-resolution timing tables with compile-time geometry parameters. It adds runtime-selectable patterns, a frame-synchronous pattern/colour update, a clock enable, and frame counting/status outputs.

Parameters:
H_ACTIVE, 1280, active pixels per line (multiple of 8)
H_FP, 110, horizontal front porch in pixels
H_SYNC, 40, horizontal sync width in pixels
H_BP, 220, horizontal back porch in pixels
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch in lines
V_SYNC, 5, vertical sync width in lines
V_BP, 20, vertical back porch in lines
HS_POL, 1, hs asserted level (1 = active-high)
VS_POL, 1, vs asserted level
DATA_W, 8, bits per colour component
CNT_W, 12, width of the h/v counters and position outputs
CHK_LOG2, 4, checkerboard square size is 2^CHK_LOG2 pixels

Ports:
clk  in  1  pixel clock; all logic is on the rising edge
reset  in  1  asynchronous, active-high reset
clk_en  in  1  advance enable; when low, all state and all outputs hold
pattern_sel  in  3  requested pattern; sampled at frame boundary
solid_rgb  in  3*DATA_W  {R,G,B} for the solid pattern; sampled at frame boundary
vid_de  out  1  data enable
vid_hs  out  1  horizontal sync (polarity HS_POL)
vid_vs  out  1  vertical sync (polarity VS_POL)
vid_r / vid_g / vid_b  out  DATA_W each  pixel colour
x_pos  out  CNT_W  h counter value matching the current outputs
y_pos  out  CNT_W  v counter value matching the current outputs
frame_start  out  1  one-cycle pulse coincident with the output of pixel (0,0)
frame_cnt  out  16  completed-frame count, wraps at 2^16
active_pattern  out  3  pattern currently being rendered

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must fit in CNT_W bits.
- Counters:
  - h_cnt steps 0..H_TOTAL-1 on each clk with clk_en=1, then wraps to 0.
  - v_cnt increments when h_cnt wraps, and wraps to 0 after V_TOTAL-1.
  - Line order is active, FP, sync, BP; frame order is the same.
- Decode:
  - de = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
  - hs asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), changing only at h_cnt=0.
- Latency: all outputs are registered with exactly 1 enabled cycle after the counter state they describe. x_pos/y_pos are that same counter state, so every output is mutually aligned.
- Frame boundary is the enabled cycle where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1. On that cycle:
  - active_pattern<=pattern_sel and solid_rgb is latched;
  - frame_cnt increments.
  - Changes to the inputs mid-frame never affect the current frame.
- Patterns (applied only when de; otherwise rgb=0):
  - 0, colour bars: 8 bars of BAR_W=H_ACTIVE/8. Bar index comes from a per-line bar counter, not a divider. Order: white, yellow, cyan, green, magenta, red, blue, black. Full scale = all-ones.
  - 1, grey ramp: R=G=B = h_cnt[DATA_W-1:0].
  - 2, checkerboard: white if h_cnt[CHK_LOG2]^v_cnt[CHK_LOG2], else black.
  - 3, solid: the latched solid_rgb.
  - 4, scrolling bar: white if ((h_cnt - {frame_cnt,1'b0}) mod 256) < 16, else black.
  - 5-7: black.
- frame_start = 1 for exactly the output cycle where x_pos=0 and y_pos=0.
- clk_en=0: counters, latches and outputs are frozen, and frame_start holds its value. Deassertion resumes exactly where it stopped.
- Reset (async assert, any time including mid-line):
  - counters=0, active_pattern=0, latched colour=0, frame_cnt=0;
  - de=0, hs=~HS_POL, vs=~VS_POL, rgb=0, x_pos=y_pos=0, frame_start=0.
  - The first enabled cycle after release outputs the state for (0,0) with frame_start=1.
  - The first frame always renders pattern 0.

Test Plan:
Small geometry for all scenarios: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1, DATA_W=8, CHK_LOG2=1 (H_TOTAL=24, frame=192 cycles, BAR_W=2).

1. Timing: free-run 2 frames with clk_en=1.
   - de high for x_pos 0..15 on y_pos 0..3 (64 cycles per frame).
   - hs high for x_pos 18..20.
   - vs high for y_pos 5..6.
   - frame_start pulses every 192 cycles; frame_cnt goes 0->1->2.
2. Colour bars: pattern 0, first line.
   - x=0..1 gives FF/FF/FF; x=2..3 gives FF/FF/00; x=14..15 gives 00/00/00.
   - rgb=0 on x=16..23.
3. Frame-synchronous select: drive pattern_sel=3 with solid_rgb=12_34_56 mid-frame 0.
   - Frame 0 stays colour bars.
   - Frame 1 gives 12/34/56 on all 64 de cycles and active_pattern=3.
4. Checkerboard and ramp:
   - Pattern 2: (x=0,y=0) black, (x=2,y=0) white, (x=2,y=2) black.
   - Pattern 1: vid_r=x_pos on all active pixels.
5. clk_en gating: hold clk_en=0 for 10 cycles at x_pos=7.
   - All outputs constant.
   - On release, the next output is x_pos=8 and the frame period stretches to 202 cycles.
6. Reset mid-operation: assert reset at y_pos=2, x_pos=5 with pattern 3 active.
   - Outputs immediately become de=0, hs=vs=0, rgb=0, frame_cnt=0.
   - After release: frame_start=1 at (0,0) and pattern 0 is rendered.
